cb_input_conditioner: RTL and testbench
=======================================

Name: cb_input_conditioner

Overview:
Sits directly upstream of the canyon_bomber core. It turns raw PS/2 key events and USB/DB9/DB15 joystick bits into the core's active-low Coin/Start/Fire inputs. Joystick contacts are debounced. Coin requests are shaped into single fixed-width pulses followed by a lockout gap, so one press or a held button yields exactly one credit. Runs in the clk_sys (12 MHz) domain.

Parameters:
COIN_PULSE, 600000, coin active-low pulse length in clk_sys cycles (50 ms); must be ≥1.
COIN_GAP, 600000, lockout cycles after each coin pulse; must be ≥1.
DEB_LEN, 12000, consecutive stable cycles needed to accept a joystick level change (1 ms); must be ≥1.
CNT_W, 20, width of coin and debounce counters; must hold max(COIN_PULSE, COIN_GAP, DEB_LEN).

Ports:
clk_sys  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
ps2_key  in  11  [10] toggles once per key event, [9] = pressed, [8:0] = scan code.
joy_fire  in  2  raw fire, [0] = P1, [1] = P2; active-high.
joy_start  in  2  raw start, [0] = P1, [1] = P2; active-high.
joy_coin  in  2  raw coin, [0] = P1, [1] = P2; active-high.
Coin1_n  out  1  to core Coin1_I; active-low.
Coin2_n  out  1  to core Coin2_I; active-low.
Start1_n  out  1  to core Start1_I; active-low.
Start2_n  out  1  to core Start2_I; active-low.
Fire1_n  out  1  to core Fire1_I; active-low.
Fire2_n  out  1  to core Fire2_I; active-low.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs = 1.
  - All key-state bits = 0.
  - Debounced joystick levels = 0 and debounce counters = 0.
  - Both coin FSMs go to IDLE with counters = 0 and previous-request registers = 0.
  - tog_q is loaded with ps2_key[10], so no spurious event follows reset.
- Keyboard:
  - An event is detected when ps2_key[10] != tog_q. tog_q follows ps2_key[10] every cycle.
  - On an event, the matching key-state bit is set to ps2_key[9].
  - Each key has its own bit: space 0x029, ctrl 0x014, A 0x01C, F1 0x005, 1 0x016, F2 0x006, 2 0x01E, 5 0x02E, 6 0x036.
  - Extended prefix is compared via the full 9-bit code. Unmapped codes are ignored.
  - Releasing one key never clears another key that is still held (e.g. space held, ctrl pressed then released → fire stays active).
- Debounce, per bit of joy_fire/joy_start/joy_coin (6 filters):
  - The raw input is registered once.
  - If the registered input differs from the debounced level, the counter increments. The level flips on the cycle the count reaches DEB_LEN, and the counter then clears.
  - If the input equals the level at any point, the counter clears.
  - Net latency from a stable input change to the debounced level = DEB_LEN+1 cycles.
- Request merge:
  - fire1 = space | ctrl | dj_fire[0]
  - fire2 = A | dj_fire[1]
  - start1 = F1 | key1 | dj_start[0]
  - start2 = F2 | key2 | dj_start[1]
  - coin1_req = key5 | dj_coin[0] | dj_coin[1]
  - coin2_req = key6
- Fire/Start outputs: registered inversion of the merge. Keyboard latency: event cycle → output changes 2 cycles later.
- Coin FSM (one per channel):
  - prev_req is registered each cycle. rise = req & ~prev_req.
  - IDLE: output 1. On rise, go to PULSE with cnt = 0.
  - PULSE: output 0. cnt++; when cnt == COIN_PULSE-1, go to GAP with cnt = 0. The output is low for exactly COIN_PULSE cycles.
  - GAP: output 1. cnt++; when cnt == COIN_GAP-1, go to IDLE.
  - Rises during PULSE/GAP are ignored, not queued.
  - A request still held on return to IDLE produces no new coin; a fresh rise is required.
  - Coin_n is registered from the state: it goes low the cycle after the state enters PULSE (latency req→Coin_n = 2 cycles from the req register).
- Both channels operate independently; simultaneous rises produce simultaneous pulses.
- Reset mid-pulse: Coin_n returns to 1 the cycle after reset is sampled high. No pulse resumes after reset releases, even with the request still held (prev_req = 0 after reset, so a held req counts as a rise only once reset is low; this is the required behaviour: one coin).

Test Plan:
Use COIN_PULSE=4, COIN_GAP=3, DEB_LEN=3 throughout.
1. Reset with ps2_key[10] = 1, release, hold ps2_key constant 20 cycles → all outputs stay 1; no phantom key event.
2. Event {tog, pressed=1, 0x029}, then {tog, pressed=1, 0x014}, then {tog, 0, 0x029} → Fire1_n = 0 two cycles after the first event and stays 0; goes 1 only after {tog, 0, 0x014}.
3. Key 5 press held 30 cycles → Coin1_n low for exactly 4 cycles, then high; no second pulse. Release, wait ≥3 cycles, press again → second 4-cycle pulse.
4. joy_coin[0] toggling every 2 cycles for 20 cycles → Coin1_n never goes low. Then hold 1 → Coin1_n falls 4+2 cycles after the hold begins (DEB_LEN+1 debounce, then 2-cycle coin latency) and stays low for 4 cycles.
5. Key-6 rise during Coin1 PULSE, plus a second joy_coin rise within the Coin1 GAP → Coin2_n pulses 4 cycles independently; Coin1 issues only one pulse.
6. Assert reset on the 2nd cycle of a Coin1 pulse with the request held → Coin1_n = 1 the next cycle. After release, exactly one new 4-cycle pulse appears; no further pulses while held.

Source files
------------

// File: rtl/cb_input_conditioner.sv
// Input conditioner in front of the canyon_bomber core: PS/2 key state, joystick debounce,
// and one-shot coin pulses with a lockout gap. All outputs are active-low.
module cb_input_conditioner #(
  parameter int COIN_PULSE = 600000,
  parameter int COIN_GAP   = 600000,
  parameter int DEB_LEN    = 12000,
  parameter int CNT_W      = 20
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [1:0]  joy_fire,
  input  logic [1:0]  joy_start,
  input  logic [1:0]  joy_coin,
  output logic        Coin1_n,
  output logic        Coin2_n,
  output logic        Start1_n,
  output logic        Start2_n,
  output logic        Fire1_n,
  output logic        Fire2_n,
  output logic [3:0]  coin_state_o
);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_GAP   = 2'd2
  } coin_state_e;

  // key_q bits: 0 space, 1 ctrl, 2 A, 3 F1, 4 '1', 5 F2, 6 '2', 7 '5', 8 '6'
  logic             tog_q;
  logic [8:0]       key_q, key_d;
  logic [5:0]       raw_q;
  logic [5:0]       lvl_q, lvl_d;
  logic [CNT_W-1:0] deb_cnt_q [6];
  logic [CNT_W-1:0] deb_cnt_d [6];
  coin_state_e      cst_q [2];
  coin_state_e      cst_d [2];
  logic [CNT_W-1:0] ccnt_q [2];
  logic [CNT_W-1:0] ccnt_d [2];
  logic [1:0]       req, prev_req_q, rise;
  logic             fire1, fire2, start1, start2;

  always_comb begin
    key_d = key_q;
    if (ps2_key[10] != tog_q) begin
      case (ps2_key[8:0])
        9'h029:  key_d[0] = ps2_key[9];
        9'h014:  key_d[1] = ps2_key[9];
        9'h01C:  key_d[2] = ps2_key[9];
        9'h005:  key_d[3] = ps2_key[9];
        9'h016:  key_d[4] = ps2_key[9];
        9'h006:  key_d[5] = ps2_key[9];
        9'h01E:  key_d[6] = ps2_key[9];
        9'h02E:  key_d[7] = ps2_key[9];
        9'h036:  key_d[8] = ps2_key[9];
        default: ;
      endcase
    end
  end

  // Level flips on the DEB_LEN-th consecutive differing sample; any agreeing sample restarts the count.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      lvl_d[i]     = lvl_q[i];
      deb_cnt_d[i] = '0;
      if (raw_q[i] != lvl_q[i]) begin
        if (deb_cnt_q[i] == CNT_W'(DEB_LEN - 1)) lvl_d[i] = raw_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign fire1  = key_q[0] | key_q[1] | lvl_q[0];
  assign fire2  = key_q[2] | lvl_q[1];
  assign start1 = key_q[3] | key_q[4] | lvl_q[2];
  assign start2 = key_q[5] | key_q[6] | lvl_q[3];
  assign req[0] = key_q[7] | lvl_q[4] | lvl_q[5];
  assign req[1] = key_q[8];
  assign rise   = req & ~prev_req_q;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cst_d[c]  = cst_q[c];
      ccnt_d[c] = ccnt_q[c];
      case (cst_q[c])
        C_IDLE: begin
          if (rise[c]) begin
            cst_d[c]  = C_PULSE;
            ccnt_d[c] = '0;
          end
        end
        C_PULSE: begin
          if (ccnt_q[c] == CNT_W'(COIN_PULSE - 1)) begin
            cst_d[c]  = C_GAP;
            ccnt_d[c] = '0;
          end else begin
            ccnt_d[c] = ccnt_q[c] + CNT_W'(1);
          end
        end
        C_GAP: begin
          if (ccnt_q[c] == CNT_W'(COIN_GAP - 1)) begin
            cst_d[c]  = C_IDLE;
            ccnt_d[c] = '0;
          end else begin
            ccnt_d[c] = ccnt_q[c] + CNT_W'(1);
          end
        end
        default: begin
          cst_d[c]  = C_IDLE;
          ccnt_d[c] = '0;
        end
      endcase
    end
  end

  // Raw joystick sampling is a plain synchronizer stage and is left out of reset.
  always_ff @(posedge clk_sys) begin
    raw_q <= {joy_coin, joy_start, joy_fire};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q      <= ps2_key[10];
      key_q      <= '0;
      lvl_q      <= '0;
      prev_req_q <= '0;
      for (int i = 0; i < 6; i++) deb_cnt_q[i] <= '0;
      for (int c = 0; c < 2; c++) begin
        cst_q[c]  <= C_IDLE;
        ccnt_q[c] <= '0;
      end
      Coin1_n  <= 1'b1;
      Coin2_n  <= 1'b1;
      Start1_n <= 1'b1;
      Start2_n <= 1'b1;
      Fire1_n  <= 1'b1;
      Fire2_n  <= 1'b1;
    end else begin
      tog_q      <= ps2_key[10];
      key_q      <= key_d;
      lvl_q      <= lvl_d;
      prev_req_q <= req;
      for (int i = 0; i < 6; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      for (int c = 0; c < 2; c++) begin
        cst_q[c]  <= cst_d[c];
        ccnt_q[c] <= ccnt_d[c];
      end
      Coin1_n  <= (cst_q[0] != C_PULSE);
      Coin2_n  <= (cst_q[1] != C_PULSE);
      Start1_n <= ~start1;
      Start2_n <= ~start2;
      Fire1_n  <= ~fire1;
      Fire2_n  <= ~fire2;
    end
  end

  assign coin_state_o = {cst_q[1], cst_q[0]};

endmodule

// File: tb/tb_cb_input_conditioner.sv
// Bench for cb_input_conditioner: directed scenarios plus random traffic, every cycle
// compared against a timestamp/window-based reference model.
module tb_cb_input_conditioner;
  localparam int CP = 4;
  localparam int CG = 3;
  localparam int DL = 3;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [1:0]  joy_fire, joy_start, joy_coin;
  logic        Coin1_n, Coin2_n, Start1_n, Start2_n, Fire1_n, Fire2_n;
  logic [3:0]  coin_state;

  int n_chk  = 0;
  int n_pass = 0;

  cb_input_conditioner #(
    .COIN_PULSE(CP), .COIN_GAP(CG), .DEB_LEN(DL), .CNT_W(20)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
    .joy_fire(joy_fire), .joy_start(joy_start), .joy_coin(joy_coin),
    .Coin1_n(Coin1_n), .Coin2_n(Coin2_n), .Start1_n(Start1_n), .Start2_n(Start2_n),
    .Fire1_n(Fire1_n), .Fire2_n(Fire2_n), .coin_state_o(coin_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  longint   m_cyc = 0;
  bit       m_tog;
  bit       m_key [int];
  bit [5:0] m_raw, m_lvl;
  bit       m_hist [6][$];
  bit [1:0] m_prev_req;
  longint   m_last_acc [2] = '{-1000, -1000};
  logic [5:0] exp_q [$];

  function automatic bit mapped(input logic [8:0] code);
    case (code)
      9'h029, 9'h014, 9'h01C, 9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit kh(input int code);
    return m_key.exists(code) && m_key[code];
  endfunction

  task automatic model_edge();
    bit [5:0] joy_now;
    bit [1:0] req;
    bit       f1, f2, s1, s2, all_diff;
    bit [1:0] low;
    joy_now = {joy_coin, joy_start, joy_fire};
    if (reset) begin
      m_key.delete();
      m_lvl      = '0;
      for (int i = 0; i < 6; i++) m_hist[i].delete();
      m_prev_req = '0;
      m_last_acc = '{-1000, -1000};
      m_tog      = ps2_key[10];
      exp_q.push_back(6'h3f);
    end else begin
      f1 = kh('h029) | kh('h014) | m_lvl[0];
      f2 = kh('h01C) | m_lvl[1];
      s1 = kh('h005) | kh('h016) | m_lvl[2];
      s2 = kh('h006) | kh('h01E) | m_lvl[3];
      req[0] = kh('h02E) | m_lvl[4] | m_lvl[5];
      req[1] = kh('h036);
      for (int c = 0; c < 2; c++) begin
        // a coin is accepted on a fresh rise once the previous pulse+gap window has elapsed
        if (req[c] && !m_prev_req[c] && m_cyc >= m_last_acc[c] + CP + CG + 1)
          m_last_acc[c] = m_cyc;
        low[c] = (m_cyc >= m_last_acc[c] + 1) && (m_cyc <= m_last_acc[c] + CP);
      end
      m_prev_req = req;
      exp_q.push_back({~low[0], ~low[1], ~s1, ~s2, ~f1, ~f2});
      if (ps2_key[10] != m_tog && mapped(ps2_key[8:0]))
        m_key[int'(ps2_key[8:0])] = ps2_key[9];
      m_tog = ps2_key[10];
      // level flips once the last DL samples since the previous flip all disagree with it
      for (int i = 0; i < 6; i++) begin
        m_hist[i].push_back(m_raw[i]);
        if (m_hist[i].size() > DL) void'(m_hist[i].pop_front());
        all_diff = (m_hist[i].size() == DL);
        foreach (m_hist[i][k]) if (m_hist[i][k] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[i] = ~m_lvl[i];
          m_hist[i].delete();
        end
      end
    end
    m_raw = joy_now;
    m_cyc++;
  endtask

  // ---------------- scoreboard / checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  int c1_pulses = 0, c1_low = 0, c2_pulses = 0, c2_low = 0;
  logic c1_prev = 1'b1, c2_prev = 1'b1;

  task automatic step();
    logic [5:0] obs;
    @(posedge clk_sys);
    model_edge();
    #1;
    obs = {Coin1_n, Coin2_n, Start1_n, Start2_n, Fire1_n, Fire2_n};
    check($sformatf("outs@%0d", m_cyc), {26'd0, obs}, {26'd0, exp_q.pop_front()});
    if (c1_prev && !Coin1_n) c1_pulses++;
    if (!Coin1_n) c1_low++;
    if (c2_prev && !Coin2_n) c2_pulses++;
    if (!Coin2_n) c2_low++;
    c1_prev = Coin1_n;
    c2_prev = Coin2_n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic key_ev(input bit pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
    step();
  endtask

  logic [8:0] codes [12] = '{9'h029, 9'h014, 9'h01C, 9'h005, 9'h016, 9'h006,
                             9'h01E, 9'h02E, 9'h036, 9'h129, 9'h114, 9'h00A};

  initial begin
    int p1, p2, l1, l2, lat;
    bit found;
    reset     = 1'b1;
    ps2_key   = 11'h400;
    joy_fire  = '0;
    joy_start = '0;
    joy_coin  = '0;

    // 1: reset with toggle high, then idle
    repeat (2) step();
    reset = 1'b0;
    repeat (20) step();
    check("t1_idle", {26'd0, Coin1_n, Coin2_n, Start1_n, Start2_n, Fire1_n, Fire2_n}, 32'h3f);

    // 2: overlapping fire keys
    key_ev(1'b1, 9'h029);
    step();
    check("t2_fire_on", {31'd0, Fire1_n}, 32'd0);
    key_ev(1'b1, 9'h014);
    key_ev(1'b0, 9'h029);
    repeat (3) step();
    check("t2_fire_held", {31'd0, Fire1_n}, 32'd0);
    key_ev(1'b0, 9'h014);
    step();
    check("t2_fire_off", {31'd0, Fire1_n}, 32'd1);

    // 3: held key 5 gives one coin; release and press again gives another
    p1 = c1_pulses; l1 = c1_low;
    key_ev(1'b1, 9'h02E);
    repeat (30) step();
    check("t3_one_pulse", c1_pulses - p1, 1);
    check("t3_pulse_len", c1_low - l1, CP);
    key_ev(1'b0, 9'h02E);
    repeat (5) step();
    key_ev(1'b1, 9'h02E);
    repeat (12) step();
    check("t3_two_pulses", c1_pulses - p1, 2);
    check("t3_two_len", c1_low - l1, 2 * CP);
    key_ev(1'b0, 9'h02E);
    repeat (10) step();

    // 4: bouncing joystick coin, then a clean hold
    p1 = c1_pulses;
    for (int i = 0; i < 20; i++) begin
      joy_coin[0] = ((i / 2) % 2) == 1;
      step();
    end
    check("t4_bounce_no_coin", c1_pulses - p1, 0);
    joy_coin[0] = 1'b0;
    repeat (4) step();
    l1 = c1_low;
    joy_coin[0] = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (!Coin1_n) break;
    end
    check("t4_latency", lat, DL + 1 + 2);
    repeat (15) step();
    check("t4_pulse_len", c1_low - l1, CP);
    check("t4_one_pulse", c1_pulses - p1, 1);
    joy_coin[0] = 1'b0;
    repeat (10) step();

    // 5: coin2 during coin1 pulse, joystick coin rise inside coin1 gap
    p1 = c1_pulses; p2 = c2_pulses; l2 = c2_low;
    key_ev(1'b1, 9'h02E);
    step();
    key_ev(1'b0, 9'h02E);
    joy_coin[1] = 1'b1;
    key_ev(1'b1, 9'h036);
    repeat (20) step();
    check("t5_c1_single", c1_pulses - p1, 1);
    check("t5_c2_pulse", c2_pulses - p2, 1);
    check("t5_c2_len", c2_low - l2, CP);
    key_ev(1'b0, 9'h036);
    joy_coin[1] = 1'b0;
    repeat (10) step();

    // 6: reset in the middle of a coin pulse with the request held
    joy_coin[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!Coin1_n) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_pulse_seen", {31'd0, found}, 32'd1);
    step();
    reset = 1'b1;
    step();
    check("t6_reset_high", {31'd0, Coin1_n}, 32'd1);
    reset = 1'b0;
    p1 = c1_pulses; l1 = c1_low;
    repeat (40) step();
    check("t6_one_more", c1_pulses - p1, 1);
    check("t6_len", c1_low - l1, CP);
    joy_coin[0] = 1'b0;
    repeat (10) step();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0)
        ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), codes[$urandom_range(0, 11)]};
      else if ($urandom_range(0, 9) == 0)
        ps2_key[9:0] = 10'($urandom_range(0, 1023));
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 9) == 0) joy_fire[b]  = ~joy_fire[b];
        if ($urandom_range(0, 9) == 0) joy_start[b] = ~joy_start[b];
        if ($urandom_range(0, 14) == 0) joy_coin[b] = ~joy_coin[b];
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
